accumulator_window_ctrl: RTL and testbench

Sequencer for the 20-bit-in / 38-bit-out signed accumulate datapath. It accepts a valid/ready sample stream with a per-sample add/subtract flag and splits it into windows of WIN_LEN samples. For each window it clears the accumulator, feeds the samples with correct stage alignment, waits for the pipeline to drain, and presents the window sum on a valid/ready result port. It sits between the sample source and the accumulator instance, which it drives through the acc_* ports.

---
 rtl/accumulator_window_ctrl.sv | 87 ++++++++
 tb/tb_accumulator_window_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_window_ctrl.sv
// Window sequencer for the 20-in / 38-out signed accumulator.
// Splits a sample stream into windows and reports each window sum.
module accumulator_window_ctrl #(
    parameter int WIN_LEN = 16,
    parameter int CW      = $clog2(WIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [19:0]   s_data,
    input  logic          s_sub,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [37:0]   m_data,
    output logic [CW-1:0] m_cnt,
    output logic          acc_rst,
    output logic [19:0]   acc_a,
    output logic          acc_sub,
    input  logic [37:0]   acc_p
);

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN1,
        DRAIN2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          accept;
    logic          win_full;
    logic          close;
    logic          load;

    assign s_ready   = (state == RUN);
    assign acc_rst   = (state == CLEAR);
    assign accept    = s_valid && s_ready;
    assign acc_a     = accept ? s_data : '0;
    assign count_inc = count + CW'(accept);
    assign win_full  = accept && (count_inc == CW'(WIN_LEN));
    // a flush closes the window only if it holds at least one sample
    assign close     = win_full || (flush && (count_inc != '0));
    assign load      = (state == DRAIN2) && (!m_valid || m_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            count   <= '0;
            acc_sub <= 1'b0;
        end else begin
            // acc_sub lines up with i1 inside the accumulator
            acc_sub <= accept && s_sub;
            case (state)
                CLEAR: begin
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    count <= count_inc;
                    if (close) state <= DRAIN1;
                end
                DRAIN1: state <= DRAIN2;
                DRAIN2: if (load) state <= CLEAR;
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_cnt   <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= acc_p;
            m_cnt   <= count;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accumulator_window_ctrl.sv
// Bench for accumulator_window_ctrl: accumulator model, window
// reference model with a result scoreboard, directed and random stimulus.
module tb_accumulator_window_ctrl;

    localparam int WIN = 4;
    localparam int CW  = $clog2(WIN + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [19:0]   s_data;
    logic          s_sub;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [37:0]   m_data;
    logic [CW-1:0] m_cnt;
    logic          acc_rst;
    logic [19:0]   acc_a;
    logic          acc_sub;
    logic [37:0]   acc_p;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        longint sum;
        int     cnt;
    } res_t;

    res_t   exp_q[$];
    longint m_sum = 0;
    int     m_num = 0;
    logic   exp_sub = 1'b0;

    always #5 clk = ~clk;

    accumulator_window_ctrl #(.WIN_LEN(WIN)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sub(s_sub), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_cnt(m_cnt),
        .acc_rst(acc_rst), .acc_a(acc_a),
        .acc_sub(acc_sub), .acc_p(acc_p)
    );

    // accumulator datapath: i1 <= A, P <= P +/- i1, synchronous clear
    logic [19:0] i1;
    logic [37:0] p;
    assign acc_p = p;
    always @(posedge clk) begin
        if (acc_rst) begin
            i1 <= '0;
            p  <= '0;
        end else begin
            i1 <= acc_a;
            if (acc_sub) p <= p - {{18{i1[19]}}, i1};
            else         p <= p + {{18{i1[19]}}, i1};
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx20(input logic [19:0] v);
        return longint'($signed(v));
    endfunction

    // monitor + reference model, sampled at negedge when inputs are stable
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_sum   = 0;
            m_num   = 0;
            exp_sub = 1'b0;
        end else begin
            chk("acc_sub", longint'(acc_sub), longint'(exp_sub));
            if (s_valid && s_ready)
                chk("acc_a", sx20(acc_a), sx20(s_data));
            else
                chk("acc_a_idle", sx20(acc_a), 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", longint'($signed(m_data)), -1);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("m_data", longint'($signed(m_data)), r.sum);
                    chk("m_cnt", longint'(m_cnt), longint'(r.cnt));
                end
            end
            exp_sub = s_valid && s_ready && s_sub;
            if (s_ready) begin
                logic acc;
                acc = s_valid;
                if (acc) begin
                    m_sum = s_sub ? m_sum - sx20(s_data) : m_sum + sx20(s_data);
                    m_num++;
                end
                if ((acc && m_num == WIN) || (flush && m_num >= 1)) begin
                    exp_q.push_back('{sum: m_sum, cnt: m_num});
                    m_sum = 0;
                    m_num = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit sub, input bit fl);
        s_valid = 1'b1;
        s_data  = 20'(d);
        s_sub   = sub;
        flush   = fl;
        for (int i = 0; i < 200; i++) begin
            if (s_ready) begin
                tick();
                s_valid = 1'b0;
                flush   = 1'b0;
                s_data  = '0;
                s_sub   = 1'b0;
                return;
            end
            tick();
        end
        chk("send_timeout", 0, 1);
        s_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (s_ready) return;
            tick();
        end
        chk("ready_timeout", 0, 1);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !m_valid) return;
            tick();
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 20'h12345;
        s_sub   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_cnt", m_cnt, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_acc_rst", acc_rst, 1);
        chk("rst_acc_a", acc_a, 0);
        chk("rst_acc_sub", acc_sub, 0);
        s_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("clear_after_rst", acc_rst, 1);
        m_ready = 1'b1;

        // basic window, latency and ready gap
        send(10, 0, 0);
        send(20, 0, 0);
        send(30, 0, 0);
        send(40, 0, 0);
        chk("lat_k_valid", m_valid, 0);
        chk("lat_k_ready", s_ready, 0);
        tick();
        chk("lat_k1_valid", m_valid, 0);
        chk("lat_k1_ready", s_ready, 0);
        tick();
        chk("lat_k2_valid", m_valid, 1);
        chk("lat_k2_data", longint'($signed(m_data)), 100);
        chk("lat_k2_cnt", m_cnt, 4);
        chk("lat_k2_ready", s_ready, 0);
        tick();
        chk("lat_k3_ready", s_ready, 1);
        drain();

        // mixed operations and extremes
        send(5, 0, 0); send(3, 1, 0); send(7, 0, 0); send(2, 1, 0);
        for (int i = 0; i < 4; i++) send(-524288, 1, 0);
        for (int i = 0; i < 4; i++) send(-524288, 0, 0);
        drain();

        // backpressure: 100 pending, 26 waits in DRAIN2
        m_ready = 1'b0;
        send(10, 0, 0); send(20, 0, 0); send(30, 0, 0); send(40, 0, 0);
        send(5, 0, 0); send(6, 0, 0); send(7, 0, 0); send(8, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid", m_valid, 1);
            chk("bp_data", longint'($signed(m_data)), 100);
            chk("bp_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("bp_reload_valid", m_valid, 1);
        chk("bp_reload_data", longint'($signed(m_data)), 26);
        chk("bp_reload_cnt", m_cnt, 4);
        drain();

        // flush cases
        send(3, 0, 0);
        send(4, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain();
        wait_ready();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("flush0_valid", m_valid, 0);
        chk("flush0_ready", s_ready, 1);
        send(9, 0, 1);
        drain();

        // reset mid-window with a pending result
        m_ready = 1'b0;
        send(11, 0, 0); send(12, 0, 0); send(13, 0, 0); send(14, 0, 0);
        send(1, 0, 0); send(2, 0, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_acc_rst", acc_rst, 1);
        chk("mid_rst_ready", s_ready, 0);
        tick();
        tick();
        reset = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (m_valid) break;
            tick();
        end
        chk("post_rst_data", longint'($signed(m_data)), 4);
        drain();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = 20'($urandom);
            s_sub   = 1'($urandom);
            flush   = ($urandom % 12) == 0;
            m_ready = ($urandom % 3) != 0;
            tick();
        end
        s_valid = 1'b0;
        flush   = 1'b0;
        drain();
        chk("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
